// File: rtl/fclass_pkg.sv
// Shared class-bit indices, format encodings and per-format field geometry
// for the RISC-V FCLASS pipeline.
package fclass_pkg;

  localparam int unsigned NUM_CLS   = 10;
  localparam int unsigned CLS_NINF  = 0;
  localparam int unsigned CLS_NNORM = 1;
  localparam int unsigned CLS_NSUB  = 2;
  localparam int unsigned CLS_NZERO = 3;
  localparam int unsigned CLS_PZERO = 4;
  localparam int unsigned CLS_PSUB  = 5;
  localparam int unsigned CLS_PNORM = 6;
  localparam int unsigned CLS_PINF  = 7;
  localparam int unsigned CLS_SNAN  = 8;
  localparam int unsigned CLS_QNAN  = 9;

  localparam logic [1:0] FMT_S   = 2'b00;
  localparam logic [1:0] FMT_D   = 2'b01;
  localparam logic [1:0] FMT_H   = 2'b10;
  localparam logic [1:0] FMT_RSV = 2'b11;

  typedef logic [NUM_CLS-1:0] fclass_mask_t;

  function automatic int unsigned fmt_exp_w(input logic [1:0] fmt);
    case (fmt)
      FMT_H:   return 5;
      FMT_S:   return 8;
      FMT_D:   return 11;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned fmt_man_w(input logic [1:0] fmt);
    case (fmt)
      FMT_H:   return 10;
      FMT_S:   return 23;
      FMT_D:   return 52;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned fmt_width(input logic [1:0] fmt);
    return 1 + fmt_exp_w(fmt) + fmt_man_w(fmt);
  endfunction

endpackage

// File: rtl/fclass_core.sv
// Combinational IEEE-754 classifier: sign/exponent/mantissa to one-hot
// FCLASS mask for a single format geometry.
module fclass_core
  import fclass_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output fclass_mask_t     o_mask
);

  logic       w_exp_ones;
  logic       w_exp_zero;
  logic       w_man_zero;
  logic [3:0] w_cls;

  assign w_exp_ones = &i_exp;
  assign w_exp_zero = ~|i_exp;
  assign w_man_zero = ~|i_man;

  always_comb begin
    w_cls = 4'(CLS_PNORM);
    if (w_exp_ones) begin
      if (w_man_zero)
        w_cls = i_sign ? 4'(CLS_NINF) : 4'(CLS_PINF);
      else
        w_cls = i_man[MAN_W-1] ? 4'(CLS_QNAN) : 4'(CLS_SNAN);
    end else if (w_exp_zero) begin
      if (w_man_zero)
        w_cls = i_sign ? 4'(CLS_NZERO) : 4'(CLS_PZERO);
      else
        w_cls = i_sign ? 4'(CLS_NSUB) : 4'(CLS_PSUB);
    end else begin
      w_cls = i_sign ? 4'(CLS_NNORM) : 4'(CLS_PNORM);
    end
  end

  assign o_mask = fclass_mask_t'(1) << w_cls;

endmodule

// File: rtl/fclass_pipe.sv
// Two-stage elastic FCLASS unit for H/S/D operands with NaN-boxing checks,
// tag pass-through and per-class saturating event counters.
module fclass_pipe
  import fclass_pkg::*;
#(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [FLEN-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_mask,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  input  logic             cnt_clr,
  input  logic [3:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value
);

  localparam int unsigned H_EW = fmt_exp_w(FMT_H);
  localparam int unsigned H_MW = fmt_man_w(FMT_H);
  localparam int unsigned H_W  = fmt_width(FMT_H);
  localparam int unsigned S_EW = fmt_exp_w(FMT_S);
  localparam int unsigned S_MW = fmt_man_w(FMT_S);
  localparam int unsigned S_W  = fmt_width(FMT_S);
  localparam int unsigned D_EW = fmt_exp_w(FMT_D);
  localparam int unsigned D_MW = fmt_man_w(FMT_D);

  localparam fclass_mask_t QNAN_MASK = fclass_mask_t'(1) << CLS_QNAN;

  logic             r_s1_valid;
  logic [FLEN-1:0]  r_s1_data;
  logic [1:0]       r_s1_fmt;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  fclass_mask_t     r_out_mask;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_illegal;

  logic [CNT_W-1:0] r_cnt [NUM_CLS];

  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_out_xfer;
  logic             w_h_boxed;
  logic             w_s_boxed;
  fclass_mask_t     w_mask_h;
  fclass_mask_t     w_mask_s;
  fclass_mask_t     w_mask_d;
  fclass_mask_t     w_s1_mask;
  logic             w_s1_illegal;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_out_valid && out_ready;

  fclass_core #(.EXP_W(H_EW), .MAN_W(H_MW)) u_core_h (
    .i_sign (r_s1_data[H_W-1]),
    .i_exp  (r_s1_data[H_W-2 -: H_EW]),
    .i_man  (r_s1_data[H_MW-1:0]),
    .o_mask (w_mask_h)
  );

  fclass_core #(.EXP_W(S_EW), .MAN_W(S_MW)) u_core_s (
    .i_sign (r_s1_data[S_W-1]),
    .i_exp  (r_s1_data[S_W-2 -: S_EW]),
    .i_man  (r_s1_data[S_MW-1:0]),
    .o_mask (w_mask_s)
  );

  generate
    if (FLEN == 64) begin : g_d
      fclass_core #(.EXP_W(D_EW), .MAN_W(D_MW)) u_core_d (
        .i_sign (r_s1_data[63]),
        .i_exp  (r_s1_data[62 -: D_EW]),
        .i_man  (r_s1_data[D_MW-1:0]),
        .o_mask (w_mask_d)
      );
    end else begin : g_no_d
      assign w_mask_d = '0;
    end

    // Single-precision operands occupy the whole register when FLEN=32.
    if (FLEN > S_W) begin : g_s_box
      assign w_s_boxed = &r_s1_data[FLEN-1:S_W];
    end else begin : g_s_nobox
      assign w_s_boxed = 1'b1;
    end
  endgenerate

  assign w_h_boxed = &r_s1_data[FLEN-1:H_W];

  always_comb begin
    w_s1_mask    = '0;
    w_s1_illegal = 1'b0;
    case (r_s1_fmt)
      FMT_S: w_s1_mask = w_s_boxed ? w_mask_s : QNAN_MASK;
      FMT_H: w_s1_mask = w_h_boxed ? w_mask_h : QNAN_MASK;
      FMT_D: begin
        if (FLEN == 64) w_s1_mask    = w_mask_d;
        else            w_s1_illegal = 1'b1;
      end
      default: w_s1_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_fmt   <= FMT_S;
      r_s1_tag   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_fmt  <= in_fmt;
        r_s1_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_mask    <= '0;
      r_out_tag     <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_mask    <= w_s1_mask;
        r_out_tag     <= r_s1_tag;
        r_out_illegal <= w_s1_illegal;
      end
    end
  end

  // Clear has priority over a coincident transfer, so that event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) r_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) r_cnt[i] <= '0;
    end else if (w_out_xfer && !r_out_illegal) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) begin
        if (r_out_mask[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int unsigned i = 0; i < NUM_CLS; i++) begin
      if (cnt_sel == 4'(i)) cnt_value = r_cnt[i];
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_mask    = r_out_mask;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_fclass_pipe.sv
// Self-checking bench for fclass_pipe: directed corner cases plus a randomized
// handshake run scored against an arithmetic IEEE-754 classification model.
module tb_fclass_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [63:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_mask;
  logic [4:0]  out_tag;
  logic        out_illegal;
  logic        cnt_clr;
  logic [3:0]  cnt_sel;
  logic [3:0]  cnt_value;

  always #50 clk = ~clk;

  fclass_pipe #(.FLEN(64), .TAG_W(5), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fmt      (in_fmt),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mask    (out_mask),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .cnt_clr     (cnt_clr),
    .cnt_sel     (cnt_sel),
    .cnt_value   (cnt_value)
  );

  typedef struct {
    logic [9:0] mask;
    logic [4:0] tag;
    logic       ill;
    int         cls;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  int   cnt_m[10];
  int   n_out    = 0;
  bit   last_in;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Classification from the format's field layout using plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] fmt, input logic [63:0] d, input logic [4:0] tag);
    exp_t e;
    int w, eb, mb;
    longint unsigned dd, v, ex, mn, emax, neg;
    e.tag = tag; e.ill = 1'b0; e.cls = 0; e.mask = '0;
    dd = d;
    case (fmt)
      2'd0: begin w = 32; eb = 8;  mb = 23; end
      2'd1: begin w = 64; eb = 11; mb = 52; end
      2'd2: begin w = 16; eb = 5;  mb = 10; end
      default: begin e.ill = 1'b1; e.cls = -1; return e; end
    endcase
    if (w < 64 && (dd >> w) != (64'hFFFF_FFFF_FFFF_FFFF >> w)) begin
      e.cls = 9;
    end else begin
      v    = (w == 64) ? dd : (dd & ((64'd1 << w) - 1));
      neg  = (v >> (w - 1)) & 1;
      emax = (64'd1 << eb) - 1;
      ex   = (v >> mb) & emax;
      mn   = v & ((64'd1 << mb) - 1);
      if (ex == emax)
        e.cls = (mn == 0) ? (neg != 0 ? 0 : 7) : (((mn >> (mb - 1)) & 1) != 0 ? 9 : 8);
      else if (ex == 0)
        e.cls = (mn == 0) ? (neg != 0 ? 3 : 4) : (neg != 0 ? 2 : 5);
      else
        e.cls = (neg != 0) ? 1 : 6;
    end
    e.mask = 10'd1 << e.cls;
    return e;
  endfunction

  // One clock: score the handshakes that will complete at the coming edge.
  task automatic cycle();
    exp_t e;
    bit   ix, ox;
    @(negedge clk);
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (ox) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_out++;
        chk("out_mask", 64'(out_mask), 64'(e.mask));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
        if (!cnt_clr && !e.ill && cnt_m[e.cls] < 15) cnt_m[e.cls]++;
      end
    end
    if (cnt_clr) foreach (cnt_m[i]) cnt_m[i] = 0;
    if (ix) sbq.push_back(model(in_fmt, in_data, in_tag));
    last_in = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string name);
    for (int i = 0; i < 10; i++) begin
      cnt_sel = 4'(i);
      #1;
      chk($sformatf("%s_cnt%0d", name, i), 64'(cnt_value), 64'(cnt_m[i]));
    end
    cnt_sel = 4'd0;
  endtask

  task automatic send(input logic [1:0] f, input logic [63:0] d, input logic [4:0] t);
    bit ok = 0;
    in_fmt = f; in_data = d; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      ok = last_in;
    end
    in_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) cycle();
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  // Fixed-latency probe on an empty pipe with the sink always ready.
  task automatic direct(input string name, input logic [1:0] f, input logic [63:0] d,
                        input logic [4:0] t, input logic [9:0] em, input logic eill);
    in_fmt = f; in_data = d; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    cycle();
    chk({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_mask"}, 64'(out_mask), 64'(em));
    chk({name, "_illegal"}, 64'(out_illegal), 64'(eill));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    cycle();
  endtask

  task automatic rnd_op(output logic [1:0] f, output logic [63:0] d);
    int r, w, eb, mb;
    longint unsigned sgn, ex, mn, v, up;
    r = int'($urandom_range(0, 15));
    f = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
    case (f)
      2'd1:    begin w = 64; eb = 11; mb = 52; end
      2'd2:    begin w = 16; eb = 5;  mb = 10; end
      default: begin w = 32; eb = 8;  mb = 23; end
    endcase
    sgn = longint'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       ex = 0;
      1:       ex = (64'd1 << eb) - 1;
      default: ex = {$urandom, $urandom} & ((64'd1 << eb) - 1);
    endcase
    mn = ($urandom_range(0, 3) == 0) ? 64'd0 : ({$urandom, $urandom} & ((64'd1 << mb) - 1));
    v  = (sgn << (w - 1)) | (ex << mb) | mn;
    if (w < 64) begin
      up = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFFF;
      v  = (up << w) | v;
    end
    d = v;
  endtask

  initial begin
    logic [1:0]  rf;
    logic [63:0] rd;
    int          k, base;

    rst_n = 1'b0; in_valid = 1'b0; in_fmt = 2'd0; in_data = '0; in_tag = '0;
    out_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = 4'd0;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_cnts("rst");

    direct("s_pnorm", 2'd0, 64'hFFFFFFFF_3F800000, 5'd17, 10'h040, 1'b0);
    direct("s_unboxed", 2'd0, 64'h00000000_7FC00000, 5'd3, 10'h200, 1'b0);
    direct("s_snan", 2'd0, 64'hFFFFFFFF_7F800001, 5'd4, 10'h100, 1'b0);
    direct("h_ninf", 2'd2, 64'hFFFFFFFF_FFFFFC00, 5'd5, 10'h001, 1'b0);
    direct("h_nsub", 2'd2, 64'hFFFFFFFF_FFFF8001, 5'd6, 10'h004, 1'b0);
    direct("h_pzero", 2'd2, 64'hFFFFFFFF_FFFF0000, 5'd7, 10'h010, 1'b0);
    direct("d_nzero", 2'd1, 64'h80000000_00000000, 5'd8, 10'h008, 1'b0);
    direct("d_pinf", 2'd1, 64'h7FF00000_00000000, 5'd9, 10'h080, 1'b0);
    chk_cnts("dir");

    // Backpressure: sink stalled for five cycles while four operands are offered.
    out_ready = 1'b0;
    k = 0; base = n_out;
    for (int c = 0; c < 5; c++) begin
      in_fmt = 2'd2; in_data = 64'hFFFFFFFF_FFFF3C00 + 64'(k); in_tag = 5'(20 + k);
      in_valid = 1'b1;
      cycle();
      if (last_in) k++;
      if (c >= 1) begin
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_mask", 64'(out_mask), 64'(sbq[0].mask));
        chk("bp_hold_tag", 64'(out_tag), 64'(sbq[0].tag));
      end
    end
    chk("bp_accepted", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int j = 2; j < 4; j++)
      send(2'd2, 64'hFFFFFFFF_FFFF3C00 + 64'(j), 5'(20 + j));
    drain();
    chk("bp_count", 64'(n_out - base), 64'd4);

    // Saturation of the +normal counter.
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    in_fmt = 2'd0; in_data = 64'hFFFFFFFF_3F800000; in_tag = 5'd1; in_valid = 1'b1;
    for (int j = 0; j < 20; j++) cycle();
    drain();
    cnt_sel = 4'd6; #1;
    chk("sat_cnt6", 64'(cnt_value), 64'd15);
    cnt_sel = 4'd12; #1;
    chk("sel_out_of_range", 64'(cnt_value), 64'd0);
    chk_cnts("sat");

    // Clear coincident with a transfer.
    in_fmt = 2'd0; in_data = 64'hFFFFFFFF_3F800000; in_tag = 5'd2; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    cnt_sel = 4'd6; #1;
    chk("clr_wins_cnt6", 64'(cnt_value), 64'd0);
    chk_cnts("clr");

    send(2'd2, 64'hFFFFFFFF_FFFF0000, 5'd11);
    drain();
    direct("rsv_fmt", 2'd3, 64'hFFFFFFFF_3F800000, 5'd30, 10'h000, 1'b1);
    chk_cnts("ill");

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      rnd_op(rf, rd);
      in_fmt = rf; in_data = rd; in_tag = 5'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    cnt_clr = 1'b0;
    drain();
    chk_cnts("rnd");

    // Reset with two operands in flight.
    out_ready = 1'b0;
    in_fmt = 2'd0; in_data = 64'hFFFFFFFF_3F800000; in_tag = 5'd12; in_valid = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_mask", 64'(out_mask), 64'd0);
    sbq.delete();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    chk_cnts("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("post_rst_no_output", 64'(out_valid), 64'd0);
    direct("post_rst", 2'd1, 64'h3FF00000_00000000, 5'd13, 10'h040, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
